// File: rtl/i_mem_ctrl.sv
// Instruction-memory controller: programming port loads the store,
// then the CPU fetches from it; unloaded or illegal fetches read as NOP.
module i_mem_ctrl #(
  parameter int MEM_SIZE = 128,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  output logic              prog_ready,
  input  logic              start,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_instr,
  output logic              cpu_stall,
  output logic [ADDR_W:0]   load_count,
  output logic              load_full,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                we;

  logic [31:0]         mem_q [MEM_SIZE];

  logic [ADDR_W-1:0]   idx;
  logic                misalign;
  logic                oob;
  logic                unloaded;
  logic                fetch_err;

  assign idx       = cpu_addr[ADDR_W+1:2];
  assign misalign  = |cpu_addr[1:0];
  assign oob       = cpu_addr[31:2] >= 30'(MEM_SIZE);
  assign unloaded  = {1'b0, idx} >= cnt_q;
  assign fetch_err = misalign || oob;

  assign cpu_instr  = (fetch_err || unloaded) ? 32'h0 : mem_q[idx];
  assign load_full  = cnt_q == (ADDR_W+1)'(MEM_SIZE);
  assign prog_ready = (state_q == LOAD) && prog_en && !load_full;
  assign cpu_stall  = state_q != RUN;
  assign load_count = cnt_q;
  assign addr_err   = err_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prog_en) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (!prog_en) begin
          state_d = RUN;
        end else if (prog_valid && prog_ready) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q + (ADDR_W+1)'(1);
        end
      end
      RUN: begin
        if (prog_en) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (fetch_err) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Store is deliberately unreset; load_count masks stale words.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= prog_data;
  end

endmodule

// File: tb/tb_i_mem_ctrl.sv
// Scoreboard bench for i_mem_ctrl: a 128-word and a 4-word instance
// share stimulus; expected words are queued when offered and popped on fetch.
module tb_i_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_en = 1'b0;
  logic        prog_valid = 1'b0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic [31:0] cpu_addr = '0;

  logic        rdy, stall, full, err;
  logic [31:0] instr;
  logic [7:0]  lc;
  logic        rdy_s, stall_s, full_s, err_s;
  logic [31:0] instr_s;
  logic [2:0]  lc_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  i_mem_ctrl u_dut (
    .clk(clk), .reset(reset), .prog_en(prog_en),
    .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(rdy), .start(start), .cpu_addr(cpu_addr),
    .cpu_instr(instr), .cpu_stall(stall), .load_count(lc),
    .load_full(full), .addr_err(err)
  );

  i_mem_ctrl #(.MEM_SIZE(4)) u_small (
    .clk(clk), .reset(reset), .prog_en(prog_en),
    .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(rdy_s), .start(start), .cpu_addr(cpu_addr),
    .cpu_instr(instr_s), .cpu_stall(stall_s), .load_count(lc_s),
    .load_full(full_s), .addr_err(err_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    prog_en = 0; prog_valid = 0; start = 0; cpu_addr = 0;
    #2 reset = 1;
    #2 reset = 0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    #2 reset = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b1 || rdy !== 1'b0 || lc !== 8'd0 || instr !== 32'h0
        || full !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b rdy=%b lc=%0d instr=%h full=%b err=%b, need 1 0 0 0 0 0",
               stall, rdy, lc, instr, full, err);
    end
    #1 reset = 0;
    repeat (3) tick();
    n_cmp++;
    if (stall !== 1'b1 || rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: stall=%b rdy=%b, need 1 0", stall, rdy);
    end
  endtask

  task automatic test_start();
    start = 1;
    tick();
    start = 0;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL start_run: stall=%b, need 0", stall);
    end
    do_reset();
    prog_en = 1; start = 1;
    tick();
    start = 0;
    n_cmp++;
    if (stall !== 1'b1 || rdy !== 1'b1) begin
      n_err++;
      $display("FAIL start_prio: stall=%b rdy=%b, need 1 1", stall, rdy);
    end
    prog_en = 0;
    do_reset();
  endtask

  task automatic test_load3();
    logic [31:0] w [3];
    w[0] = 32'h2008_0005; w[1] = 32'h2009_0003; w[2] = 32'h0109_5020;
    prog_en = 1;
    tick();
    n_cmp++;
    if (stall !== 1'b1 || rdy !== 1'b1) begin
      n_err++;
      $display("FAIL load3_enter: stall=%b rdy=%b, need 1 1", stall, rdy);
    end
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1; prog_data = w[i];
      exp_q.push_back(w[i]);
      tick();
    end
    prog_valid = 0; prog_en = 0;
    tick();
    n_cmp++;
    if (lc !== 8'd3 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL load3_done: lc=%0d stall=%b, need 3 0", lc, stall);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 32'(4 * i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (instr !== e) begin
        n_err++;
        $display("FAIL load3_fetch%0d: got %h, need %h", i, instr, e);
      end
    end
    cpu_addr = 12;
    #1;
    tick();
    n_cmp++;
    if (instr !== 32'h0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL load3_unloaded: instr=%h err=%b, need 0 0", instr, err);
    end
    cpu_addr = 0;
  endtask

  task automatic test_backpressure();
    prog_en = 1;
    tick();
    n_cmp++;
    if (stall !== 1'b1 || lc !== 8'd0) begin
      n_err++;
      $display("FAIL bp_enter: stall=%b lc=%0d, need 1 0", stall, lc);
    end
    for (int i = 0; i < 8; i++) begin
      prog_valid = (i % 2 == 0);
      prog_data = 32'hA000_0000 + 32'(i);
      if (prog_valid) exp_q.push_back(prog_data);
      #1;
      n_cmp++;
      if (rdy !== 1'b1) begin
        n_err++;
        $display("FAIL bp_ready%0d: got %b, need 1", i, rdy);
      end
      tick();
    end
    prog_valid = 0; prog_en = 0;
    tick();
    n_cmp++;
    if (lc !== 8'd4) begin
      n_err++;
      $display("FAIL bp_count: got %0d, need 4", lc);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 32'(4 * i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (instr !== e) begin
        n_err++;
        $display("FAIL bp_fetch%0d: got %h, need %h", i, instr, e);
      end
    end
    cpu_addr = 16;
    #1;
    n_cmp++;
    if (instr !== 32'h0) begin
      n_err++;
      $display("FAIL bp_tail: got %h, need 0", instr);
    end
    cpu_addr = 0;
  endtask

  task automatic test_full();
    do_reset();
    prog_en = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      prog_valid = 1;
      prog_data = 32'hB000_0000 + 32'(i);
      if (i < 4) exp_q.push_back(prog_data);
      #1;
      n_cmp++;
      if (rdy_s !== (i < 4)) begin
        n_err++;
        $display("FAIL full_ready%0d: got %b, need %b", i, rdy_s, i < 4);
      end
      tick();
      n_cmp++;
      if (full_s !== (i >= 3)) begin
        n_err++;
        $display("FAIL full_flag%0d: got %b, need %b", i, full_s, i >= 3);
      end
    end
    n_cmp++;
    if (lc_s !== 3'd4 || instr_s !== 32'hB000_0000) begin
      n_err++;
      $display("FAIL full_state: lc=%0d mem0=%h, need 4 b0000000", lc_s, instr_s);
    end
    prog_valid = 0; prog_en = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 32'(4 * i);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (instr_s !== e) begin
        n_err++;
        $display("FAIL full_fetch%0d: got %h, need %h", i, instr_s, e);
      end
    end
    cpu_addr = 16;
    #1;
    n_cmp++;
    if (instr_s !== 32'h0) begin
      n_err++;
      $display("FAIL full_oob: got %h, need 0", instr_s);
    end
    cpu_addr = 0;
    tick();
  endtask

  task automatic test_errors();
    cpu_addr = 2;
    #1;
    n_cmp++;
    if (instr !== 32'h0) begin
      n_err++;
      $display("FAIL err_misalign_instr: got %h, need 0", instr);
    end
    tick();
    cpu_addr = 0;
    tick();
    n_cmp++;
    if (err !== 1'b1 || instr !== 32'hB000_0000) begin
      n_err++;
      $display("FAIL err_sticky: err=%b instr=%h, need 1 b0000000", err, instr);
    end
    cpu_addr = 4 * 128;
    #1;
    n_cmp++;
    if (instr !== 32'h0) begin
      n_err++;
      $display("FAIL err_oob_instr: got %h, need 0", instr);
    end
    cpu_addr = 0;
    start = 1;
    tick();
    start = 0;
    prog_en = 1;
    tick();
    n_cmp++;
    if (err !== 1'b0 || stall !== 1'b1 || lc !== 8'd0) begin
      n_err++;
      $display("FAIL err_reload: err=%b stall=%b lc=%0d, need 0 1 0", err, stall, lc);
    end
    prog_valid = 1; prog_data = 32'hC0DE_0001;
    exp_q.push_back(prog_data);
    tick();
    prog_valid = 0; prog_en = 0;
    tick();
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reload_fetch0: instr=%h stall=%b, need %h 0", instr, stall, e);
    end
    cpu_addr = 4;
    #1;
    n_cmp++;
    if (instr !== 32'h0) begin
      n_err++;
      $display("FAIL reload_fetch1: got %h, need 0", instr);
    end
    cpu_addr = 0;
  endtask

  task automatic test_reset_mid_load();
    prog_en = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1; prog_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    #2 reset = 1;
    #1;
    prog_valid = 0; prog_en = 0;
    #1 reset = 0;
    tick();
    n_cmp++;
    if (stall !== 1'b1 || lc !== 8'd0 || rdy !== 1'b0) begin
      n_err++;
      $display("FAIL midload_reset: stall=%b lc=%0d rdy=%b, need 1 0 0", stall, lc, rdy);
    end
    for (int i = 0; i < 2; i++) begin
      cpu_addr = 32'(4 * i);
      #1;
      n_cmp++;
      if (instr !== 32'h0) begin
        n_err++;
        $display("FAIL midload_fetch%0d: got %h, need 0", i, instr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load3();
    test_backpressure();
    test_full();
    test_errors();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
